// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO. The baud divisor is sampled
// when a byte is popped, so each frame keeps one bit period from start to stop.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          cycles_per_bit,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]           mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 wrReady_q, empty_q;
  state_t               state_q;
  logic [7:0]           shift_q;
  logic [2:0]           bitIdx_q;
  logic [DIV_WIDTH-1:0] divCnt_q, divLatch_q, divEff;
  logic                 tx_q;
  logic                 push, pop;

  assign push   = wr_valid && wrReady_q;
  assign pop    = (state_q == IDLE) && enable && !empty_q;
  assign divEff = (cycles_per_bit == '0) ? DIV_WIDTH'(1) : cycles_per_bit;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= wr_data;
    end
  end

  // Ready and empty are registered from the next count so both track each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      wrReady_q <= 1'b1;
      empty_q   <= 1'b1;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q   <= count_d;
      wrReady_q <= (count_d != CW'(FIFO_DEPTH));
      empty_q   <= (count_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitIdx_q   <= '0;
      divCnt_q   <= '0;
      divLatch_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            shift_q    <= mem_q[rdPtr_q];
            divLatch_q <= divEff;
            divCnt_q   <= divEff - DIV_WIDTH'(1);
          end
        end
        START: begin
          if (divCnt_q == '0) begin
            state_q  <= DATA;
            tx_q     <= shift_q[0];
            bitIdx_q <= '0;
            divCnt_q <= divLatch_q - DIV_WIDTH'(1);
          end else begin
            divCnt_q <= divCnt_q - DIV_WIDTH'(1);
          end
        end
        DATA: begin
          if (divCnt_q == '0) begin
            divCnt_q <= divLatch_q - DIV_WIDTH'(1);
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              shift_q  <= {1'b0, shift_q[7:1]};
              tx_q     <= shift_q[1];
            end
          end else begin
            divCnt_q <= divCnt_q - DIV_WIDTH'(1);
          end
        end
        STOP: begin
          if (divCnt_q == '0) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
          end else begin
            divCnt_q <= divCnt_q - DIV_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign wr_ready   = wrReady_q;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;
  assign fifo_empty = empty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: stimulus queues expected frames, a serial monitor
// decodes tx cycle by cycle and checks level, busy, length and inter-frame gap.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] cycles_per_bit;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        fifo_empty;

  int checks = 0;
  int errors = 0;
  int framesDone = 0;

  typedef struct {
    logic [7:0] data;
    int         cpb;
    int         gap;
    bit         abortOk;
  } frameExp_t;

  frameExp_t sbQueue[$];

  uart_tx_fifo #(.FIFO_DEPTH(8), .DIV_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .cycles_per_bit (cycles_per_bit),
    .wr_valid       (wr_valid),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .tx             (tx),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .fifo_empty     (fifo_empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Writes one byte; queues the frame it should produce when expectTx is set.
  task automatic applyStimulus(input logic [7:0] d, input bit expectTx, input int cpbExp,
                               input int gapExp, input bit abortOk);
    frameExp_t e;
    if (expectTx) begin
      e.data = d; e.cpb = cpbExp; e.gap = gapExp; e.abortOk = abortOk;
      sbQueue.push_back(e);
    end
    wr_valid = 1'b1;
    wr_data  = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic waitFrames(input int n, input int budget);
    int goal;
    goal = framesDone + n;
    for (int i = 0; i < budget && framesDone < goal; i++) @(posedge clk);
    #1;
    if (framesDone < goal) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_wait: got %0d frames, expected %0d", framesDone, goal);
    end
  endtask

  task automatic waitBusy(input int budget);
    int i;
    for (i = 0; i < budget && busy !== 1'b1; i++) @(negedge clk);
    if (busy !== 1'b1) checkOutput("busy_wait", {31'd0, busy}, 32'd1);
  endtask

  // Serial monitor: every frame is compared level-by-level against the queued byte.
  initial begin
    int        idle;
    int        bad;
    int        gapSeen;
    int        bitNo;
    bit        aborted;
    logic      lvl;
    logic [7:0] got;
    frameExp_t cur;
    idle = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        idle = 0;
      end else if (tx !== 1'b0) begin
        idle++;
      end else if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frame: got start bit, expected idle line");
        for (int k = 0; k < 1000 && tx === 1'b0; k++) @(negedge clk);
        idle = 0;
      end else begin
        cur = sbQueue.pop_front();
        gapSeen = idle;
        bad = 0;
        aborted = 1'b0;
        got = '0;
        for (int c = 0; c < 10 * cur.cpb; c++) begin
          if (c > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bitNo = c / cur.cpb;
          if (bitNo == 0)      lvl = 1'b0;
          else if (bitNo == 9) lvl = 1'b1;
          else                 lvl = cur.data[bitNo-1];
          if (tx !== lvl || busy !== 1'b1) bad++;
          if (bitNo >= 1 && bitNo <= 8 && (c % cur.cpb) == cur.cpb / 2) got[bitNo-1] = tx;
        end
        checks++;
        if (aborted) begin
          if (!cur.abortOk) begin
            errors++;
            $display("[TB] FAIL frame_abort: got aborted frame for %02h, expected complete frame", cur.data);
          end
          idle = 0;
        end else begin
          @(negedge clk);
          if (tx !== 1'b1 || busy !== 1'b0) bad++;
          if (cur.abortOk) begin
            errors++;
            $display("[TB] FAIL frame_reset: got complete frame %02h, expected reset abort", got);
          end else if (bad != 0 || got !== cur.data) begin
            errors++;
            $display("[TB] FAIL frame: got byte %02h with %0d bad cycles, expected byte %02h cpb %0d",
                     got, bad, cur.data, cur.cpb);
          end
          if (cur.gap >= 0) begin
            checks++;
            if (gapSeen != cur.gap) begin
              errors++;
              $display("[TB] FAIL frame_gap: got %0d idle cycles, expected %0d", gapSeen, cur.gap);
            end
          end
          framesDone++;
          idle = 1;
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    cycles_per_bit = 16'd4;
    wr_valid       = 1'b0;
    wr_data        = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", {31'd0, tx}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_count", {28'd0, fifo_count}, 32'd0);
    checkOutput("reset_empty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("reset_ready", {31'd0, wr_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single byte 0x55 at 4 cycles per bit");
    enable = 1'b1;
    applyStimulus(8'h55, 1, 4, -1, 0);
    waitFrames(1, 200);

    $display("[TB] back-to-back frames at 2 cycles per bit");
    enable = 1'b0;
    cycles_per_bit = 16'd2;
    applyStimulus(8'hA5, 1, 2, -1, 0);
    applyStimulus(8'h3C, 1, 2, 1, 0);
    applyStimulus(8'hFF, 1, 2, 1, 0);
    applyStimulus(8'h00, 1, 2, 1, 0);
    checkOutput("b2b_count_full", {28'd0, fifo_count}, 32'd4);
    enable = 1'b1;
    waitFrames(4, 400);
    checkOutput("b2b_count_drained", {28'd0, fifo_count}, 32'd0);
    checkOutput("b2b_empty", {31'd0, fifo_empty}, 32'd1);

    $display("[TB] full FIFO drops the ninth byte");
    enable = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(8'(i), (i <= 8), 2, (i == 1) ? -1 : 1, 0);
    end
    checkOutput("full_ready", {31'd0, wr_ready}, 32'd0);
    checkOutput("full_count", {28'd0, fifo_count}, 32'd8);
    enable = 1'b1;
    waitFrames(8, 800);
    checkOutput("full_drained_ready", {31'd0, wr_ready}, 32'd1);

    $display("[TB] divisor 0 and 1");
    cycles_per_bit = 16'd0;
    applyStimulus(8'h96, 1, 1, -1, 0);
    waitFrames(1, 100);
    cycles_per_bit = 16'd1;
    applyStimulus(8'h69, 1, 1, -1, 0);
    waitFrames(1, 100);

    $display("[TB] divisor change mid-frame");
    enable = 1'b0;
    cycles_per_bit = 16'd4;
    applyStimulus(8'h12, 1, 4, -1, 0);
    applyStimulus(8'h34, 1, 8, 1, 0);
    enable = 1'b1;
    waitBusy(20);
    repeat (10) @(posedge clk);
    #1;
    cycles_per_bit = 16'd8;
    waitFrames(2, 400);

    $display("[TB] enable dropped during bit 3");
    enable = 1'b0;
    cycles_per_bit = 16'd4;
    applyStimulus(8'hC3, 1, 4, -1, 0);
    applyStimulus(8'h5A, 1, 4, -1, 0);
    enable = 1'b1;
    waitBusy(20);
    repeat (18) @(posedge clk);
    #1;
    enable = 1'b0;
    waitFrames(1, 200);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("hold_busy", {31'd0, busy}, 32'd0);
    checkOutput("hold_count", {28'd0, fifo_count}, 32'd1);
    applyStimulus(8'h11, 1, 4, 1, 0);
    checkOutput("hold_write_count", {28'd0, fifo_count}, 32'd2);
    enable = 1'b1;
    waitFrames(2, 400);

    $display("[TB] reset during a frame");
    applyStimulus(8'hE7, 1, 4, -1, 1);
    applyStimulus(8'h81, 0, 4, -1, 0);
    waitBusy(20);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_mid_count", {28'd0, fifo_count}, 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("rst_after_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_after_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_after_sb", sbQueue.size(), 32'd0);

    $display("[TB] message OK newline");
    cycles_per_bit = 16'd3;
    applyStimulus(8'h4F, 1, 3, -1, 0);
    applyStimulus(8'h4B, 1, 3, 1, 0);
    applyStimulus(8'h0A, 1, 3, 1, 0);
    waitFrames(3, 400);
    checkOutput("final_empty", {31'd0, fifo_empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-serial UART transmitter with an internal transmit FIFO. It is the transmit end of the serial link whose receive end is the bench UART monitor on mprj_io[6].
- Sits behind the peripheral bus as the TX path of the SoC UART peripheral. Software pushes bytes and the block serialises them as 8N1 frames.
- Baud rate is set at run time by a cycles-per-bit divisor.

Parameters:
- FIFO_DEPTH, 8, TX FIFO depth in bytes; must be a power of two, 2..32.
- DIV_WIDTH, 16, width of the cycles_per_bit divisor input.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = frames may start; 0 = no new frame starts.
- cycles_per_bit  input  DIV_WIDTH  clock cycles per serial bit; 0 is treated as 1.
- wr_valid  input  1  byte write request.
- wr_data  input  8  byte to transmit.
- wr_ready  output  1  FIFO can accept a byte (not full).
- tx  output  1  serial output, idle high.
- busy  output  1  a frame is in progress (state != IDLE).
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.
- fifo_empty  output  1  fifo_count == 0.

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, fifo_count=0, fifo_empty=1, wr_ready=1, FSM=IDLE, pointers=0, bit counter=0, divider=0.
- Write: a byte is pushed on any rising edge where wr_valid && wr_ready. wr_ready = !full and is registered state.
  - When full, wr_ready=0 and the write is dropped, even if a pop occurs in the same cycle.
- Simultaneous push and pop (FIFO not full, not empty): fifo_count is unchanged and data order is preserved.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when enable && !fifo_empty. The pop and the latching of both the byte and cycles_per_bit happen on that edge. tx goes low on the same edge, so tx is low in the cycle after the pop.
  - START: tx=0 for one bit period, then -> DATA with bit index 0.
  - DATA: tx = shift[0] (LSB first) for one bit period per bit. After bit 7 -> STOP.
  - STOP: tx=1 for one bit period, then -> IDLE.
  - Back-to-back: if the FIFO is non-empty and enable=1 at the end of STOP, the FSM passes through IDLE for exactly one cycle and then starts the next frame.
  - Frame length is therefore 10*max(cycles_per_bit,1) cycles, plus 1 idle cycle between frames.
- Bit period: a down-counter is loaded with the latched divisor minus 1 at each bit start. The bit ends when the counter reaches 0.
  - A cycles_per_bit change during a frame takes effect from the next frame only.
- enable deasserted mid-frame: the current frame completes normally, then the FSM stays in IDLE. The FIFO still accepts writes.
- Reset mid-frame: tx returns high immediately (async) and queued bytes are discarded.
- busy = 1 in START, DATA and STOP, including the final stop-bit cycle.
- fifo_count and fifo_empty are registered and update on the edge of the push or pop.

Test Plan:
- Single byte: cycles_per_bit=4, enable=1, write 0x55 -> tx low 1 cycle after the pop. tx sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles. busy high for exactly 40 cycles, then tx=1.
- Back-to-back: write 0xA5, 0x3C, 0xFF, 0x00 at cycles_per_bit=2 -> four frames decoded LSB-first in order, with a 1-cycle idle gap between frames. fifo_count goes 4 -> 0.
- Full FIFO: enable=0, write 9 bytes 0x01..0x09 -> wr_ready=0 after the 8th byte and fifo_count=8. Set enable=1 -> only 0x01..0x08 are transmitted; 0x09 is dropped.
- Divisor edge cases: cycles_per_bit=0 -> 10-cycle frame. cycles_per_bit=1 -> 10-cycle frame. Change cycles_per_bit from 4 to 8 mid-frame -> the current frame stays 40 cycles and the next frame is 80 cycles.
- Enable and reset: deassert enable during bit 3 of 0xC3 -> the frame completes and the next queued byte is held. Assert rst_n=0 during a frame -> tx=1 and fifo_count=0 immediately, and no residual frame after release.
- System loop: the firmware pushes "OK\n" at the bench UART baud -> the bench UART monitor on mprj_io[6] prints "OK".
